// File: rtl/div_unit.sv
// div_unit -- multi-cycle restoring divider for the execute stage.
//
// Performs one shift-subtract step per clock on a (2*WIDTH+1)-bit working
// register, so a divide with a nonzero divisor takes WIDTH+2 rising edges from
// the edge that samples start_i (that edge counted as the first) until ready_o
// rises.  A zero divisor short-circuits through BYZERO and returns zero.
//
// Parameters
//   WIDTH        operand width in bits; the result is 2*WIDTH bits wide
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   signed_div_i 1 = signed divide, 0 = unsigned divide
//   opdata1_i    dividend, sampled only on the IDLE start edge
//   opdata2_i    divisor, sampled only on the IDLE start edge
//   start_i      divide request, level-held until the result is consumed
//   annul_i      cancels the operation in progress (pipeline flush)
//   result_o     registered {remainder, quotient} (HI, LO)
//   ready_o      registered, result_o is valid
//
// Configuration
//   DIV_UNIT_SIGNED_EN  when defined, signed_div_i selects signed division
//                       (magnitudes are divided, then the quotient/remainder
//                       are negated as needed).  When undefined, signed_div_i
//                       is ignored and every divide is unsigned.

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BYZERO = 2'd1;
  localparam logic [1:0] ST_ON     = 2'd2;
  localparam logic [1:0] ST_END    = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  // Working register: [2W:W] partial remainder, [W-1:0] dividend bits that
  // shift out at the top while quotient bits shift in at the bottom.
  logic [2*WIDTH:0]   work;
  logic [WIDTH-1:0]   divisor;

  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH:0]   work_step;

  logic [WIDTH-1:0]   dividend_in;
  logic [WIDTH-1:0]   divisor_in;
  logic [WIDTH-1:0]   quo_final;
  logic [WIDTH-1:0]   rem_final;

  logic               start_ok;

  // A request is only honoured when not simultaneously flushed.
  assign start_ok = start_i & ~annul_i;

  // One restoring step: shift the whole pair left, trial-subtract the divisor
  // from the partial remainder and keep the difference only when it did not
  // go negative; the quotient bit shifted in records which case occurred.
  // The partial remainder is always below the divisor, so after doubling and
  // bringing in one bit it still fits in WIDTH+1 bits and work[2W] never
  // carries information into the next step.
  always_comb begin
    shifted   = {work[2*WIDTH-1:0], 1'b0};
    diff      = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};
    work_step = shifted;
    if (!diff[WIDTH]) begin
      work_step = {diff, shifted[WIDTH-1:1], 1'b1};
    end
  end

`ifdef DIV_UNIT_SIGNED_EN
  logic neg_quo;
  logic neg_rem;
  logic unused_work_msb;

  assign unused_work_msb = work[2*WIDTH];

  // Signed operands are converted to magnitudes before entering the unsigned
  // datapath.  The most-negative value negates to itself, which read as an
  // unsigned magnitude is exactly right, so MIN/-1 wraps naturally to MIN.
  always_comb begin
    dividend_in = opdata1_i;
    divisor_in  = opdata2_i;
    if (signed_div_i && opdata1_i[WIDTH-1]) begin
      dividend_in = {WIDTH{1'b0}} - opdata1_i;
    end
    if (signed_div_i && opdata2_i[WIDTH-1]) begin
      divisor_in = {WIDTH{1'b0}} - opdata2_i;
    end
  end

  // Sign fixups applied in the final ON cycle: truncation toward zero means
  // the quotient is negative when the operand signs differ and the remainder
  // carries the sign of the dividend.
  always_comb begin
    quo_final = work[WIDTH-1:0];
    rem_final = work[2*WIDTH-1:WIDTH];
    if (neg_quo) begin
      quo_final = {WIDTH{1'b0}} - work[WIDTH-1:0];
    end
    if (neg_rem) begin
      rem_final = {WIDTH{1'b0}} - work[2*WIDTH-1:WIDTH];
    end
  end

  // The sign flags are captured alongside the operands so later changes to
  // signed_div_i or the operand inputs cannot disturb an operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (state == ST_IDLE && start_ok && opdata2_i != '0) begin
      neg_quo <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
      neg_rem <= signed_div_i & opdata1_i[WIDTH-1];
    end
  end
`else
  logic unused_inputs;

  // signed_div_i has no meaning in an unsigned-only build; the top bit of the
  // working register is never needed either (see the step logic above).
  assign unused_inputs = signed_div_i ^ work[2*WIDTH];
  assign dividend_in   = opdata1_i;
  assign divisor_in    = opdata2_i;
  assign quo_final     = work[WIDTH-1:0];
  assign rem_final     = work[2*WIDTH-1:WIDTH];
`endif

  // Main control: IDLE waits for a request, BYZERO answers a zero divisor
  // after one extra cycle, ON iterates WIDTH times and then publishes the
  // result, END holds the result until the execute stage drops start_i.
  // A flush in ON takes precedence over the iteration step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (start_ok) begin
            if (opdata2_i == '0) begin
              state <= ST_BYZERO;
            end else begin
              work    <= {{(WIDTH+1){1'b0}}, dividend_in};
              divisor <= divisor_in;
              cnt     <= '0;
              state   <= ST_ON;
            end
          end
        end

        ST_BYZERO: begin
          result_o <= '0;
          ready_o  <= 1'b1;
          state    <= ST_END;
        end

        ST_ON: begin
          if (annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
            state    <= ST_IDLE;
          end else if (cnt != CNT_W'(WIDTH)) begin
            work <= work_step;
            cnt  <= cnt + 1'b1;
          end else begin
            result_o <= {rem_final, quo_final};
            ready_o  <= 1'b1;
            state    <= ST_END;
          end
        end

        ST_END: begin
          if (!start_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        default: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
